cr_xp10_decomp_fe_align_ctrl: RTL and testbench
===============================================

# cr_xp10_decomp_fe_align_ctrl

Frame-level sequencer for the XP10 decompressor front-end data aligner. It loads the per-frame bit offset from the header parser and paces aligner reads (`align_ack`) against a 2-entry output skid buffer. It detects end-of-frame, drains the skid buffer and pulses `align_clear` so the aligner FIFO and history are empty before the next frame. It sits between the front-end aligner and the downstream symbol/bit-stream consumer.

## Interface
Parameters:
- `SKID_DEPTH`, 2: output buffer entries; fixed at 2 for this revision.
- `STAT_W`, 16: width of the frame and word statistics counters.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `hdr_offset_valid`  in  1  one-cycle pulse: frame header parsed, payload offset available.
- `hdr_offset`  in  6  payload start bit offset within the first data word (0..63).
- `abort`  in  1  one-cycle pulse: kill current frame.
- `align_rdata`  in  fe_dp_bus_t  aligned word from the aligner.
- `align_rd`  in  1  `align_rdata` valid this cycle.
- `align_pre_eof`  in  1  aligner has seen eof on its current input word.
- `align_afull`  in  1  aligner FIFO almost full.
- `align_offset`  out  6  bit offset applied by the aligner.
- `align_ack`  out  1  permission for the aligner to pop and emit one word.
- `align_clear`  out  1  one-cycle flush of the aligner FIFO and state.
- `up_stall`  out  1  back-pressure to the aligner writer; equals `align_afull`.
- `out_data`  out  fe_dp_bus_t  head of the skid buffer.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready`.
- `frame_active`  out  1  high in RUN and DRAIN.
- `err_hdr_unexp`  out  1  one-cycle pulse: `hdr_offset_valid` arrived outside IDLE.
- `stat_frames`  out  STAT_W  completed frames (CLEAR entries not caused by abort); wraps.
- `stat_words`  out  STAT_W  words pushed into the skid buffer; wraps.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, CLEAR.
  - IDLE: on `hdr_offset_valid`, load `align_offset <= hdr_offset` and go to RUN.
  - RUN: `align_ack = (cnt < 2) && !abort`. Each `align_rd` pushes `align_rdata` into the skid buffer and increments `stat_words`. An `align_rd` with `align_rdata.eof=1` goes to DRAIN.
  - DRAIN: `align_ack=0`. When `cnt==0`, go to CLEAR.
  - CLEAR: `align_clear=1` for exactly one cycle, `align_offset <= 0`, `stat_frames++` unless entered by abort; next state IDLE.
- **abort** in RUN or DRAIN: discard all skid entries (`cnt <= 0`), go to CLEAR, `stat_frames` unchanged. An abort in IDLE or CLEAR is ignored.
- `align_rd` asserted while `align_ack=0` is a protocol violation. The word is dropped and does not count.
- `align_rdata.eob` and `sof` pass through in `out_data` unchanged. `eob` does not change state.
- `align_pre_eof` is informational only. It does not change the ack policy, because the aligner emits its tail word through the normal ack path.
- `hdr_offset_valid` outside IDLE: pulse `err_hdr_unexp` next cycle; `align_offset` unchanged.
- **Skid buffer:** 2-entry FIFO with count `cnt` (0..2), in order, with simultaneous push and pop allowed. Push is never accepted at `cnt==2`; this is guaranteed by the ack rule.
- `align_offset` is constant from the IDLE→RUN transition until CLEAR.

## Timing
- **Reset values:** state=IDLE; `align_offset`=0; `align_ack`=0; `align_clear`=0; `out_valid`=0; `out_data`=0; `frame_active`=0; `err_hdr_unexp`=0; `stat_*`=0; `cnt`=0. `up_stall` follows `align_afull`.
- `align_ack` is combinational from registered state and `cnt`, plus `abort` gating. `align_rd` returns in the same cycle.
- Latency: `align_rd` in cycle N gives `out_valid` in N+1 when the buffer was empty.
- Header to first ack: `hdr_offset_valid` in cycle N, RUN and the new `align_offset` in N+1, `align_ack` possible in N+1.
- End of frame: the last pop at cycle M with `cnt` reaching 0 gives DRAIN→CLEAR at M+1, `align_clear` high during M+1, IDLE at M+2.
  - If the eof word is popped in the same cycle it is pushed into an empty buffer, the minimum eof-to-`align_clear` distance is 2 cycles.
- Sustained throughput is 1 word/cycle with `out_ready` held high.
- `hdr_offset_valid` during CLEAR is an error. It is not queued.

## Test plan
- Offset 0, 4-word frame, eof on word 4, `out_ready`=1 → 4 outputs in order, `align_clear` pulses once two cycles after the eof push, `stat_frames`=1, `stat_words`=4.
- `hdr_offset`=13, 3 words → `align_offset`=13 from the cycle after the header through CLEAR, then 0 in IDLE.
- `out_ready` low for 5 cycles mid-frame → `cnt` saturates at 2, `align_ack`=0, no words lost, order preserved after release.
- Abort with `cnt`=2 in RUN → `out_valid` drops next cycle, one `align_clear`, `stat_frames` unchanged, new header is accepted afterwards.
- `hdr_offset_valid` with `hdr_offset`=40 during RUN → `err_hdr_unexp` pulse, `align_offset` unchanged.
- Reset asserted mid-DRAIN → all outputs at reset values immediately; after release, IDLE with no `align_clear` pulse.

Source files
------------

// File: rtl/cr_xp10_decomp_fe_align_ctrl.sv
// XP10 decompressor front-end aligner sequencer: loads the frame bit offset, paces
// aligner pops against a 2-entry output skid buffer and flushes the aligner at end of frame.

package cr_xp10_decomp_fe_pkg;
  typedef struct packed {
    logic        sof;
    logic        eob;
    logic        eof;
    logic [63:0] data;
  } fe_dp_bus_t;
endpackage

module cr_xp10_decomp_fe_align_ctrl
  import cr_xp10_decomp_fe_pkg::*;
#(
  parameter int SKID_DEPTH = 2,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hdr_offset_valid,
  input  logic [5:0]        hdr_offset,
  input  logic              abort,
  input  fe_dp_bus_t        align_rdata,
  input  logic              align_rd,
  input  logic              align_pre_eof,
  input  logic              align_afull,
  output logic [5:0]        align_offset,
  output logic              align_ack,
  output logic              align_clear,
  output logic              up_stall,
  output fe_dp_bus_t        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_active,
  output logic              err_hdr_unexp,
  output logic [STAT_W-1:0] stat_frames,
  output logic [STAT_W-1:0] stat_words
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  cnt_next;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        clr_by_abort;
  logic        push;
  logic        pop;
  fe_dp_bus_t  skid [2];
  logic        unused_ok;

  // The aligner pushes its tail word through the normal ack path, so pre-eof is not needed.
  assign unused_ok = &{1'b0, align_pre_eof};

  assign align_ack    = (state == RUN) && (cnt < 2'(SKID_DEPTH)) && !abort;
  assign push         = align_rd && align_ack;
  assign out_valid    = (cnt != 2'd0);
  assign pop          = out_valid && out_ready;
  assign out_data     = out_valid ? skid[rd_ptr] : '0;
  assign up_stall     = align_afull;
  assign frame_active = (state == RUN) || (state == DRAIN);

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + 2'd1;
      2'b01:   cnt_next = cnt - 2'd1;
      default: cnt_next = cnt;
    endcase
  end

  // Storage needs no reset: out_data is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      skid[wr_ptr] <= align_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      align_offset  <= 6'd0;
      align_clear   <= 1'b0;
      err_hdr_unexp <= 1'b0;
      cnt           <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      clr_by_abort  <= 1'b0;
      stat_frames   <= '0;
      stat_words    <= '0;
    end else begin
      align_clear   <= 1'b0;
      err_hdr_unexp <= hdr_offset_valid && (state != IDLE);
      cnt           <= cnt_next;
      if (push) begin
        wr_ptr     <= ~wr_ptr;
        stat_words <= stat_words + STAT_W'(1);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case (state)
        IDLE: begin
          if (hdr_offset_valid) begin
            align_offset <= hdr_offset;
            state        <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            cnt          <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            clr_by_abort <= 1'b1;
            align_clear  <= 1'b1;
            state        <= CLEAR;
          end else if (push && align_rdata.eof) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            cnt          <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            clr_by_abort <= 1'b1;
            align_clear  <= 1'b1;
            state        <= CLEAR;
          end else if (cnt_next == 2'd0) begin
            clr_by_abort <= 1'b0;
            align_clear  <= 1'b1;
            state        <= CLEAR;
          end
        end
        CLEAR: begin
          align_offset <= 6'd0;
          if (!clr_by_abort) begin
            stat_frames <= stat_frames + STAT_W'(1);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_xp10_decomp_fe_align_ctrl.sv
// Self-checking bench for cr_xp10_decomp_fe_align_ctrl: table of frames plus hand sequences,
// with a queue scoreboard of words expected at the skid buffer output.
module tb_cr_xp10_decomp_fe_align_ctrl;
  import cr_xp10_decomp_fe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_offset_valid = 1'b0;
  logic [5:0]  hdr_offset = 6'd0;
  logic        abort = 1'b0;
  fe_dp_bus_t  align_rdata = '0;
  logic        align_rd = 1'b0;
  logic        align_pre_eof = 1'b0;
  logic        align_afull = 1'b0;
  logic [5:0]  align_offset;
  logic        align_ack;
  logic        align_clear;
  logic        up_stall;
  fe_dp_bus_t  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        frame_active;
  logic        err_hdr_unexp;
  logic [15:0] stat_frames;
  logic [15:0] stat_words;

  always #5 clk = ~clk;

  cr_xp10_decomp_fe_align_ctrl #(.SKID_DEPTH(2), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_offset_valid(hdr_offset_valid), .hdr_offset(hdr_offset), .abort(abort),
    .align_rdata(align_rdata), .align_rd(align_rd), .align_pre_eof(align_pre_eof),
    .align_afull(align_afull), .align_offset(align_offset), .align_ack(align_ack),
    .align_clear(align_clear), .up_stall(up_stall), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .frame_active(frame_active),
    .err_hdr_unexp(err_hdr_unexp), .stat_frames(stat_frames), .stat_words(stat_words)
  );

  int errors = 0;
  int checks = 0;

  // Expected-behaviour model
  fe_dp_bus_t  exp_q[$];
  logic        exp_run = 0, exp_drain = 0, clr_due = 0, clr_abort = 0, err_due = 0;
  logic [5:0]  exp_off = 0;
  logic [15:0] exp_frames = 0, exp_words = 0;

  typedef struct {
    logic [5:0] off;
    int nwords;
    int stall_at;
    int stall_len;
    int abort_at;
    int hdr_at;
    int gaps;
  } frame_t;
  frame_t tbl[6];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic fe_dp_bus_t mkword(input int w, input int n);
    fe_dp_bus_t x;
    x.data = {$urandom, $urandom};
    x.sof  = (w == 0);
    x.eob  = w[0];
    x.eof  = (w == n - 1);
    return x;
  endfunction

  // One clock: drive at negedge, check at +1, update model, advance to next negedge.
  task automatic tick(input logic rd, input fe_dp_bus_t d, input logic rdy, input logic ab,
                      input logic hv, input logic [5:0] ho, output logic acc);
    logic eack, in_idle, new_clr;
    fe_dp_bus_t e;
    align_rd = rd; align_rdata = d; out_ready = rdy; abort = ab;
    hdr_offset_valid = hv; hdr_offset = ho;
    align_afull = 1'($urandom_range(0, 1));
    #1;
    eack = exp_run && (exp_q.size() < 2) && !ab;
    chk("align_ack", align_ack, eack);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("align_clear", align_clear, clr_due);
    chk("frame_active", frame_active, exp_run || exp_drain);
    chk("align_offset", align_offset, exp_off);
    chk("err_hdr_unexp", err_hdr_unexp, err_due);
    chk("stat_frames", stat_frames, exp_frames);
    chk("stat_words", stat_words, exp_words);
    chk("up_stall", up_stall, align_afull);

    in_idle = !exp_run && !exp_drain && !clr_due;
    acc = rd && eack;
    if (rdy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_data", out_data, e);
      $display("out word data=%h sof=%0b eob=%0b eof=%0b", out_data.data, out_data.sof,
               out_data.eob, out_data.eof);
    end
    err_due = hv && !in_idle;
    if (acc) begin
      exp_q.push_back(d);
      exp_words++;
      if (d.eof) begin exp_run = 0; exp_drain = 1; end
    end
    if (clr_due) begin
      exp_off = 0;
      if (!clr_abort) exp_frames++;
    end
    new_clr = 0;
    if (ab && (exp_run || exp_drain)) begin
      exp_q.delete(); exp_run = 0; exp_drain = 0; new_clr = 1; clr_abort = 1;
    end else if (exp_drain && exp_q.size() == 0) begin
      exp_drain = 0; new_clr = 1; clr_abort = 0;
    end
    if (hv && in_idle) begin exp_run = 1; exp_off = ho; end
    clr_due = new_clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_tick();
    logic a;
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0, a);
  endtask

  task automatic run_frame(input frame_t f, input int idx);
    int w = 0;
    int cyc = 0;
    logic aborted = 0, rd, rdy, ab, hv, acc, done = 0;
    fe_dp_bus_t d;
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1, f.off, acc);
    while (cyc < 200 && !done) begin
      rdy = !(cyc >= f.stall_at && cyc < f.stall_at + f.stall_len);
      ab  = (cyc == f.abort_at);
      hv  = (cyc == f.hdr_at);
      rd  = (w < f.nwords) && !aborted && (f.gaps == 0 || $urandom_range(0, 2) != 0);
      d   = rd ? mkword(w, f.nwords) : '0;
      tick(rd, d, rdy, ab, hv, 6'd40, acc);
      if (acc) w++;
      if (ab) aborted = 1;
      cyc++;
      done = ((w == f.nwords) || aborted) && !exp_run && !exp_drain && !clr_due;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: frame %0d got no completion, required completion in 200 cycles", idx);
    end
    idle_tick();
    $display("frame %0d off=%0d words_sent=%0d aborted=%0b frames=%0d words=%0d",
             idx, f.off, w, aborted, stat_frames, stat_words);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_align_offset", align_offset, 0);
    chk("rst_align_ack", align_ack, 0);
    chk("rst_align_clear", align_clear, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_err_hdr_unexp", err_hdr_unexp, 0);
    chk("rst_stat_frames", stat_frames, 0);
    chk("rst_stat_words", stat_words, 0);
  endtask

  initial begin
    logic a;
    fe_dp_bus_t d;
    //          off    n  stall_at len abort hdr  gaps
    tbl[0] = '{6'd0,  4, 1000, 0, 1000, 1000, 0};
    tbl[1] = '{6'd13, 3, 1000, 0, 1000, 1000, 0};
    tbl[2] = '{6'd5,  8, 2,    5, 1000, 1000, 0};
    tbl[3] = '{6'd7,  6, 1,    6, 4,    1000, 0};
    tbl[4] = '{6'd33, 5, 1000, 0, 1000, 2,    0};
    tbl[5] = '{6'd63, 10, 3,   2, 1000, 1000, 1};

    @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle_tick();

    for (int i = 0; i < 6; i++) run_frame(tbl[i], i);

    // Single-word frame; header arriving during CLEAR is flagged and not queued; abort in IDLE ignored.
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'd21, a);
    d = mkword(0, 1);
    tick(1'b1, d, 1'b1, 1'b0, 1'b0, 6'd0, a);
    idle_tick();
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'd50, a);
    tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 6'd0, a);
    idle_tick();
    $display("hdr-in-clear sequence frames=%0d err_checked", stat_frames);

    // Asynchronous reset while draining a full skid buffer.
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'd9, a);
    d = mkword(0, 2);
    tick(1'b1, d, 1'b0, 1'b0, 1'b0, 6'd0, a);
    d = mkword(1, 2);
    tick(1'b1, d, 1'b0, 1'b0, 1'b0, 6'd0, a);
    align_rd = 1'b0; hdr_offset_valid = 1'b0;
    chk("drain_frame_active", frame_active, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    exp_run = 0; exp_drain = 0; clr_due = 0; clr_abort = 0; err_due = 0;
    exp_off = 0; exp_frames = 0; exp_words = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_tick();
    $display("reset-in-drain sequence complete");

    run_frame(tbl[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
